// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the dmem_responder data-memory responder:
// FSM state encoding, word-index width and the response latency bound.
package dmem_responder_pkg;

    // Controller states; DUMP is only reachable when the dump feature is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    // Word storage: 64 words addressed by byte-address bits [8:3].
    localparam int DEPTH_MAX = 64;
    localparam int IDX_W     = $clog2(DEPTH_MAX);

    // Wait-state bound: LATENCY is legal in 0..7, so the wait counter needs 3 bits.
    localparam int LAT_MAX   = 7;
    localparam int WAIT_W    = $clog2(LAT_MAX + 1);

    // Value loaded into the wait counter at accept. BUSY lasts (load + 1)
    // cycles, so LATENCY=0 and LATENCY=1 both give a single BUSY cycle.
    function automatic logic [WAIT_W-1:0] wait_load(input int lat);
        if (lat <= 0) begin
            return '0;
        end
        return WAIT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/dmem_store.sv
// Word storage for dmem_responder: one synchronous write port, one
// asynchronous (combinational) read port.
module dmem_store
    import dmem_responder_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [N-1:0]     i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [N-1:0]     o_rdata
);

    logic [N-1:0] r_mem [DEPTH];

    // Write port: one word per clock when enabled.
    // NOTE: the array has no reset branch on purpose; contents must survive
    // reset, and leaving it out keeps the array mappable onto RAM cells.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// wait-state latency, misaligned/out-of-range error detection and an
// optional full-contents dump stream.
// Optional feature: define DMEM_RESPONDER_DUMP_EN to build the DUMP state;
// without it the dump input is ignored and the dump outputs are tied to 0.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int N       = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         req_ready,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    input  logic         rsp_ready,
    input  logic         dump,
    output logic         dump_valid,
    output logic [5:0]   dump_addr,
    output logic [N-1:0] dump_data
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_req_ready;
    logic                w_accept;
    logic                w_busy_done;
    logic                w_commit;
    logic                w_addr_err;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [N-1:0]        w_rd_data;

    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_write;
    logic                r_err;
    logic [IDX_W-1:0]    r_idx;
    logic [N-1:0]        r_wdata;
    logic [N-1:0]        r_rsp_rdata;
    logic                r_rsp_err;

`ifdef DMEM_RESPONDER_DUMP_EN
    logic [IDX_W-1:0]    r_dump_cnt;
    logic                w_dump_last;
`endif

    // Misaligned (low three bits set) or beyond the 512-byte window.
    assign w_addr_err  = (req_addr[2:0] != 3'd0) || (req_addr[N-1:9] != '0);
    assign w_accept    = w_req_ready && req_valid;
    assign w_busy_done = (r_state == ST_BUSY) && (r_wait_cnt == '0);
    // Reset on the commit edge must suppress the write, so it gates the enable.
    assign w_commit    = w_busy_done && reset && r_write && !r_err;

`ifdef DMEM_RESPONDER_DUMP_EN
    assign w_dump_last = (r_dump_cnt == IDX_W'(DEPTH - 1));
`endif

    // State register.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef DMEM_RESPONDER_DUMP_EN
                if (dump) begin
                    w_next_state = ST_DUMP;
                end else begin
                    w_req_ready = 1'b1;
                    if (req_valid) begin
                        w_next_state = ST_BUSY;
                    end
                end
`else
                w_req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = ST_BUSY;
                end
`endif
            end
            ST_BUSY: begin
                if (r_wait_cnt == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
`ifdef DMEM_RESPONDER_DUMP_EN
            ST_DUMP: begin
                if (w_dump_last) begin
                    w_next_state = ST_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        // No request may be accepted while reset is held.
        if (!reset) begin
            w_req_ready = 1'b0;
        end
    end

    assign req_ready = w_req_ready;

    // Wait counter and response registers; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wait_cnt <= wait_load(LATENCY);
            end else if ((r_state == ST_BUSY) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (w_busy_done) begin
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_write || r_err) ? '0 : w_rd_data;
            end
        end
    end

    // Request capture at accept; only meaningful while a transaction is open.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_err   <= w_addr_err;
            r_idx   <= req_addr[8:3];
            r_wdata <= req_wdata;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

`ifdef DMEM_RESPONDER_DUMP_EN
    // Dump address counter: walks 0..DEPTH-1 while in DUMP, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dump_cnt <= '0;
        end else if (r_state == ST_DUMP) begin
            r_dump_cnt <= r_dump_cnt + 1'b1;
        end else begin
            r_dump_cnt <= '0;
        end
    end

    assign w_rd_idx   = (r_state == ST_DUMP) ? r_dump_cnt : r_idx;
    assign dump_valid = (r_state == ST_DUMP);
    assign dump_addr  = dump_valid ? r_dump_cnt : 6'd0;
    assign dump_data  = dump_valid ? w_rd_data : '0;
`else
    logic w_unused_dump;

    assign w_unused_dump = dump;
    assign w_rd_idx      = r_idx;
    assign dump_valid    = 1'b0;
    assign dump_addr     = 6'd0;
    assign dump_data     = '0;
`endif

    dmem_store #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: scoreboard of expected responses
// against a word-array model, LATENCY=2 main instance plus a LATENCY=0 instance.
module tb_dmem_responder;

    localparam int N = 64;

    typedef struct {
        logic [N-1:0] rdata;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;

    logic         req_valid, req_write, req_ready;
    logic [N-1:0] req_addr, req_wdata;
    logic         rsp_valid, rsp_err, rsp_ready;
    logic [N-1:0] rsp_rdata;
    logic         dump, dump_valid;
    logic [5:0]   dump_addr;
    logic [N-1:0] dump_data;

    logic         req_valid_0, req_write_0, req_ready_0;
    logic [N-1:0] req_addr_0, req_wdata_0;
    logic         rsp_valid_0, rsp_err_0, rsp_ready_0;
    logic [N-1:0] rsp_rdata_0;
    logic         dump_valid_0;
    logic [5:0]   dump_addr_0;
    logic [N-1:0] dump_data_0;

    logic [N-1:0] model [64];
    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.N(N), .DEPTH(64), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .dump(dump), .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data)
    );

    dmem_responder #(.N(N), .DEPTH(64), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_0), .req_write(req_write_0), .req_addr(req_addr_0),
        .req_wdata(req_wdata_0), .req_ready(req_ready_0),
        .rsp_valid(rsp_valid_0), .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0),
        .rsp_ready(rsp_ready_0),
        .dump(1'b0), .dump_valid(dump_valid_0), .dump_addr(dump_addr_0), .dump_data(dump_data_0)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the LATENCY=2 instance; holds rsp_ready low for
    // 'hold' cycles once the response appears. Called at posedge+1.
    task automatic do_txn(input logic wr, input logic [N-1:0] addr,
                          input logic [N-1:0] wdata, input int hold);
        exp_t         e;
        logic [N-1:0] first_rdata;
        logic         first_err;
        int           n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        e.err   = (addr[2:0] != 3'd0) || (addr[N-1:9] != '0);
        e.rdata = (wr || e.err) ? '0 : model[addr[8:3]];
        if (wr && !e.err) model[addr[8:3]] = wdata;
        sb_q.push_back(e);
        step();
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        check("rsp_valid_wait", rsp_valid, 1);
        check("latency", n, 3);
        first_rdata = rsp_rdata;
        first_err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, first_rdata);
            check("hold_err", rsp_err, first_err);
            check("hold_req_ready", req_ready, 0);
        end
        e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_cleared", rsp_valid, 0);
        check("idle_ready", req_ready, 1);
    endtask

    // One transaction on the LATENCY=0 instance.
    task automatic do_txn0(input logic wr, input logic [N-1:0] addr,
                           input logic [N-1:0] wdata, input logic [N-1:0] exp_rdata);
        int n;
        req_valid_0 = 1'b1;
        req_write_0 = wr;
        req_addr_0  = addr;
        req_wdata_0 = wdata;
        check("l0_req_ready", req_ready_0, 1);
        step();
        req_valid_0 = 1'b0;
        n = 1;
        while (!rsp_valid_0 && n < 30) begin
            step();
            n++;
        end
        check("l0_latency", n, 2);
        check("l0_rdata", rsp_rdata_0, exp_rdata);
        check("l0_err", rsp_err_0, 0);
        rsp_ready_0 = 1'b1;
        step();
        rsp_ready_0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] old_w4;
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; dump = 1'b0;
        req_valid_0 = 1'b0; req_write_0 = 1'b0; req_addr_0 = '0; req_wdata_0 = '0;
        rsp_ready_0 = 1'b0;

        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_dump_valid", dump_valid, 0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", req_ready, 1);

        // Fill every word with known data.
        for (int i = 0; i < 64; i++) begin
            do_txn(1'b1, N'(i * 8), {$urandom, $urandom}, 0);
        end

        // Store then load at 0x10.
        do_txn(1'b1, 64'h10, 64'h1122334455667788, 0);
        do_txn(1'b0, 64'h10, '0, 0);
        check("model_w2", model[2], 64'h1122334455667788);

        // Misaligned and out-of-range accesses.
        do_txn(1'b0, 64'h0C, '0, 0);
        do_txn(1'b1, 64'h0C, 64'hDEADBEEFDEADBEEF, 0);
        do_txn(1'b1, 64'h208, 64'hCAFECAFECAFECAFE, 0);
        do_txn(1'b0, 64'h1_0000_0000, '0, 0);

        // Backpressure: response held for 5 cycles.
        do_txn(1'b0, 64'h18, '0, 5);
        do_txn(1'b1, 64'h28, 64'h0123456789ABCDEF, 5);

        // Reset on the last BUSY cycle of a store to 0x20 must abort it.
        old_w4    = model[4];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = ~old_w4;
        check("abort_accept_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        check("abort_busy_no_rsp", rsp_valid, 0);
        reset = 1'b0;
        step();
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_rsp_err", rsp_err, 0);
        reset = 1'b1;
        #1;
        check("abort_idle", req_ready, 1);
        do_txn(1'b0, 64'h20, '0, 0);

`ifdef DMEM_RESPONDER_DUMP_EN
        // Dump wins over a simultaneous request; request accepted afterwards.
        dump      = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h10;
        #1;
        check("dump_prio_ready", req_ready, 0);
        step();
        dump = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check("dump_valid", dump_valid, 1);
            check("dump_addr", dump_addr, N'(i));
            check("dump_data", dump_data, model[i]);
            check("dump_req_ready", req_ready, 0);
            step();
        end
        check("dump_end_valid", dump_valid, 0);
        check("dump_end_addr", dump_addr, 0);
        do_txn(1'b0, 64'h10, '0, 0);
`else
        // Without the feature, dump is ignored and the stream stays quiet.
        dump = 1'b1;
        #1;
        check("nodump_ready", req_ready, 1);
        do_txn(1'b0, 64'h10, '0, 0);
        check("nodump_valid", dump_valid, 0);
        check("nodump_data", dump_data, 0);
        dump = 1'b0;
`endif

        // LATENCY=0 instance: store and load both take 2 cycles.
        do_txn0(1'b1, 64'h08, 64'hA5A5_5A5A_F00D_BEEF, '0);
        do_txn0(1'b0, 64'h08, '0, 64'hA5A5_5A5A_F00D_BEEF);

        // Sweep every word against the model.
        for (int i = 0; i < 64; i++) begin
            do_txn(1'b0, N'(i * 8), '0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter N, default 64, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of N-bit words stored.
REQ-003 SHALL have parameter LATENCY, default 2, wait cycles between accept and response (legal 0..7).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  N  byte address; word index = req_addr[8:3].
REQ-009 SHALL have port req_wdata  input  N  store data.
REQ-010 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_rdata  output  N  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned or out-of-range access.
REQ-014 SHALL have port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-015 SHALL have ports dump input 1, dump_valid output 1, dump_addr output 6, dump_data output N: contents dump stream.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP, DUMP; req_ready = 1 only in IDLE with reset deasserted.
REQ-017 SHALL, in IDLE, on accept, register write flag, word index, wdata, and error flag (req_addr[2:0] != 0 or req_addr[N-1:9] != 0), then enter BUSY.
REQ-018 SHALL stay in BUSY exactly LATENCY cycles (LATENCY=0: one cycle), using a wait counter loaded at accept.
REQ-019 SHALL, on BUSY->RESP edge, commit a non-error store to memory and latch load data from the addressed word.
REQ-020 SHALL hold rsp_valid, rsp_rdata, and rsp_err stable in RESP until rsp_ready; on that handshake edge it SHALL return to IDLE.
REQ-021 SHALL never modify memory on an error access; loads with error return rsp_rdata = 0.
REQ-022 SHALL make accept-to-rsp_valid latency exactly LATENCY+1 cycles, or 2 cycles when LATENCY=0.
REQ-023 SHALL, with dump and req_valid both high in IDLE, give dump priority; req_ready is then 0 that cycle.
REQ-024 SHALL ignore dump outside IDLE; it is sampled again on return to IDLE.
REQ-025 SHALL drive dump_valid=0, dump_addr=0, dump_data=0 whenever not in DUMP.

Reset
REQ-026 SHALL, on clk edge with reset=0, force IDLE, clear wait counter and dump counter, and drive rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0.
REQ-027 SHALL abort any in-flight transaction on reset; an uncommitted store SHALL NOT be written.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 SHALL honour macro DMEM_RESPONDER_DUMP_EN: when defined, dump in IDLE enters DUMP, which asserts dump_valid for DEPTH consecutive cycles with dump_addr 0..DEPTH-1 and dump_data = mem[dump_addr], then returns to IDLE.
REQ-030 SHALL, without DMEM_RESPONDER_DUMP_EN, omit DUMP state logic, ignore dump, and tie dump_valid, dump_addr, and dump_data to 0.

Structure
REQ-031 SHALL place the state enum, DEPTH-derived index width, and the LATENCY bound in shared package dmem_responder_pkg.
REQ-032 SHALL instantiate sub-module dmem_store for the storage array: synchronous write and asynchronous read.

Verification
REQ-033 Store 0x1122334455667788 at addr 0x10 with LATENCY=2 -> rsp_valid 3 cycles after accept, rsp_err=0; then a load from 0x10 returns 0x1122334455667788.
REQ-034 Load from addr 0x0C (misaligned) -> rsp_err=1, rsp_rdata=0; a store to 0x0C leaves every word unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0; the next accept occurs only after the handshake.
REQ-036 Assert reset=0 during BUSY of a store to 0x20 -> next cycle IDLE, rsp_valid=0, and word 4 retains its old value.
REQ-037 With DMEM_RESPONDER_DUMP_EN, assert dump and req_valid together in IDLE -> 64 dump_valid cycles, addr 0..63 matching contents; the request is accepted afterward.
REQ-038 With LATENCY=0 -> accept-to-rsp_valid is exactly 2 cycles for both a load and a store.
